// File: rtl/control_pkg.sv
// Control encodings shared by the decode and writeback paths.
package control_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/pipelinestages_pkg.sv
// Inter-stage pipeline records and memory-stage state definitions.
package pipelinestages_pkg;
  import control_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus_4;
    logic [31:0] alu_result;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    wb_sel_e     wb_sel;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_plus_4;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        reg_write;
    wb_sel_e     wb_sel;
  } mem_wb_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

  localparam int DMEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Counts REQ cycles without ack; expire flags the last permitted wait cycle.
module dmem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates at LIMIT so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + CW'(1);
    end
  end

  assign expire = (count == LIMIT);

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores over a req/ack port and builds the MEM/WB record.
module mem_stage
  import pipelinestages_pkg::*;
  import control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  ex_mem_t     ex_mem_i,
  output mem_wb_t     mem_wb_o,
  output logic        mem_stall_o,
  output logic        mem_err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i
);

  mem_state_e state, next_state;
  logic       mem_op;
  logic       capture, complete, abandon;
  logic       cnt_clear, cnt_en, expire;
  mem_wb_t    wb_next;

  assign mem_op     = ex_mem_i.valid && (ex_mem_i.mem_read || ex_mem_i.mem_write);
  assign dmem_req_o = (state == REQ);

  dmem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .enable(cnt_en),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Ack is checked before expire so a completion on the limit cycle is not an error.
  always_comb begin
    next_state  = state;
    mem_stall_o = 1'b0;
    capture     = 1'b0;
    complete    = 1'b0;
    abandon     = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          mem_stall_o = 1'b1;
          capture     = 1'b1;
          cnt_clear   = 1'b1;
          next_state  = REQ;
        end
      end
      REQ: begin
        if (dmem_ack_i) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (expire) begin
          abandon    = 1'b1;
          next_state = IDLE;
        end else begin
          mem_stall_o = 1'b1;
          cnt_en      = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wb_next            = '0;
    wb_next.valid      = ex_mem_i.valid;
    wb_next.pc_plus_4  = ex_mem_i.pc_plus_4;
    wb_next.alu_result = ex_mem_i.alu_result;
    wb_next.rd         = ex_mem_i.rd;
    wb_next.reg_write  = ex_mem_i.reg_write;
    wb_next.wb_sel     = ex_mem_i.wb_sel;
    if (complete && !ex_mem_i.mem_write) begin
      wb_next.mem_data = dmem_rdata_i;
    end
    // An abandoned access retires as a harmless no-op.
    if (abandon) begin
      wb_next.valid     = 1'b1;
      wb_next.reg_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wb_o     <= '0;
      mem_err_o    <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
    end else begin
      if ((state == IDLE && !mem_op) || complete || abandon) begin
        mem_wb_o <= wb_next;
      end else begin
        mem_wb_o <= '0;
      end
      if (capture) begin
        dmem_we_o    <= ex_mem_i.mem_write;
        dmem_addr_o  <= {ex_mem_i.alu_result[31:2], 2'b00};
        dmem_wdata_o <= ex_mem_i.rs2;
      end
      if ((capture && ex_mem_i.mem_read && ex_mem_i.mem_write) || abandon) begin
        mem_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a short timeout limit.
module tb_mem_stage;
  import control_pkg::*;
  import pipelinestages_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  ex_mem_t     ex_mem = '0;
  mem_wb_t     mem_wb;
  logic        stall, err, req, we, ack = 1'b0;
  logic [31:0] addr, wdata, rdata = '0;

  int tests = 0;
  int fails = 0;
  int stall_cnt = 0;
  int req_cnt = 0;
  int s0, r0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_mem_i    (ex_mem),
    .mem_wb_o    (mem_wb),
    .mem_stall_o (stall),
    .mem_err_o   (err),
    .dmem_req_o  (req),
    .dmem_we_o   (we),
    .dmem_addr_o (addr),
    .dmem_wdata_o(wdata),
    .dmem_rdata_i(rdata),
    .dmem_ack_i  (ack)
  );

  always @(negedge clk) begin
    if (rst_n && stall) stall_cnt++;
    if (rst_n && req)   req_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_req", req, 0);
    chk("rst_err", err, 0);
    chk("rst_wb", {31'd0, mem_wb === '0}, 1);
    chk("rst_addr", addr, 0);
    tick();
    rst_n = 1'b1;

    // ALU pass-through
    s0 = stall_cnt;
    ex_mem = '0;
    ex_mem.valid = 1; ex_mem.alu_result = 32'h0000_1234; ex_mem.rd = 5;
    ex_mem.reg_write = 1; ex_mem.pc_plus_4 = 32'h40; ex_mem.wb_sel = WB_ALU;
    #1 chk("alu_stall", stall, 0);
    tick();
    ex_mem = '0;
    chk("alu_valid", mem_wb.valid, 1);
    chk("alu_res", mem_wb.alu_result, 32'h1234);
    chk("alu_rd", mem_wb.rd, 5);
    chk("alu_rw", mem_wb.reg_write, 1);
    chk("alu_pc", mem_wb.pc_plus_4, 32'h40);
    chk("alu_mdata", mem_wb.mem_data, 0);
    chk("alu_nostall", stall_cnt - s0, 0);

    // Load, ack in first REQ cycle
    s0 = stall_cnt; r0 = req_cnt;
    ex_mem.valid = 1; ex_mem.mem_read = 1; ex_mem.alu_result = 32'h100;
    ex_mem.rd = 7; ex_mem.reg_write = 1; ex_mem.wb_sel = WB_MEM;
    #1 chk("ld_stall0", stall, 1);
    tick();
    chk("ld_req", req, 1);
    chk("ld_addr", addr, 32'h100);
    chk("ld_we", we, 0);
    chk("ld_bubble", mem_wb.valid, 0);
    ack = 1; rdata = 32'hCAFE_BABE;
    #1 chk("ld_stall1", stall, 0);
    tick();
    ack = 0; rdata = '0; ex_mem = '0;
    chk("ld_valid", mem_wb.valid, 1);
    chk("ld_data", mem_wb.mem_data, 32'hCAFE_BABE);
    chk("ld_rd", mem_wb.rd, 7);
    chk("ld_req_off", req, 0);
    chk("ld_stalls", stall_cnt - s0, 1);
    chk("ld_reqs", req_cnt - r0, 1);

    // Store, 3 wait cycles; ack lands on the limit cycle
    s0 = stall_cnt; r0 = req_cnt;
    ex_mem.valid = 1; ex_mem.mem_write = 1; ex_mem.rs2 = 32'hA5A5_A5A5;
    ex_mem.alu_result = 32'h203; ex_mem.wb_sel = WB_ALU;
    tick();
    chk("st_addr", addr, 32'h200);
    chk("st_wdata", wdata, 32'hA5A5_A5A5);
    chk("st_we", we, 1);
    tick();
    tick();
    tick();
    ack = 1;
    #1 chk("st_stall_ack", stall, 0);
    tick();
    ack = 0; ex_mem = '0;
    chk("st_valid", mem_wb.valid, 1);
    chk("st_mdata", mem_wb.mem_data, 0);
    chk("st_alu", mem_wb.alu_result, 32'h203);
    chk("st_err", err, 0);
    chk("st_stalls", stall_cnt - s0, 4);
    chk("st_reqs", req_cnt - r0, 4);

    // Timeout, never acked
    s0 = stall_cnt; r0 = req_cnt;
    ex_mem.valid = 1; ex_mem.mem_read = 1; ex_mem.alu_result = 32'h300;
    ex_mem.rd = 9; ex_mem.reg_write = 1; ex_mem.wb_sel = WB_MEM;
    tick();
    tick();
    tick();
    tick();
    #1 chk("to_stall_last", stall, 0);
    tick();
    ex_mem = '0;
    chk("to_err", err, 1);
    chk("to_valid", mem_wb.valid, 1);
    chk("to_rw", mem_wb.reg_write, 0);
    chk("to_mdata", mem_wb.mem_data, 0);
    chk("to_rd", mem_wb.rd, 9);
    chk("to_reqs", req_cnt - r0, 4);
    chk("to_stalls", stall_cnt - s0, 4);
    tick();
    tick();
    chk("to_sticky", err, 1);

    // Reset mid-access, then a stray ack
    ex_mem.valid = 1; ex_mem.mem_read = 1; ex_mem.alu_result = 32'h400;
    tick();
    chk("rm_req", req, 1);
    rst_n = 0;
    #1;
    chk("rm_req_drop", req, 0);
    chk("rm_err", err, 0);
    chk("rm_addr", addr, 0);
    chk("rm_wb", {31'd0, mem_wb === '0}, 1);
    ex_mem = '0;
    tick();
    rst_n = 1;
    ack = 1; rdata = 32'hDEAD_BEEF;
    tick();
    ack = 0; rdata = '0;
    chk("rm_stray_req", req, 0);
    chk("rm_stray_valid", mem_wb.valid, 0);
    chk("rm_stray_data", mem_wb.mem_data, 0);
    chk("rm_stray_err", err, 0);

    // Next load completes normally
    ex_mem.valid = 1; ex_mem.mem_read = 1; ex_mem.alu_result = 32'h500;
    ex_mem.rd = 3; ex_mem.reg_write = 1;
    tick();
    chk("rl_addr", addr, 32'h500);
    ack = 1; rdata = 32'h1234_5678;
    tick();
    ack = 0; ex_mem = '0;
    chk("rl_data", mem_wb.mem_data, 32'h1234_5678);
    chk("rl_valid", mem_wb.valid, 1);
    chk("rl_err", err, 0);

    // Read and write both set: store with error
    ex_mem.valid = 1; ex_mem.mem_read = 1; ex_mem.mem_write = 1;
    ex_mem.rs2 = 32'h11; ex_mem.alu_result = 32'h600;
    tick();
    chk("rw_we", we, 1);
    chk("rw_err", err, 1);
    ack = 1; rdata = 32'hFFFF_FFFF;
    tick();
    ack = 0; ex_mem = '0;
    chk("rw_mdata", mem_wb.mem_data, 0);
    chk("rw_valid", mem_wb.valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
